// File: rtl/rx_control_module_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, frame width
// default and the 50 MHz / 9600 bps baud counter constants.
package rx_control_module_pkg;

   localparam int DATA_BITS_DEF = 8;
   localparam int BPS_FULL      = 5208;
   localparam int BPS_HALF      = 2604;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } rx_state_e;

endpackage

// File: rtl/rx_h2l_detect.sv
// Two-flop synchronizer for the raw serial line plus a history flop that
// flags a high-to-low transition of the synchronized line.
module rx_h2l_detect (
   input  logic CLK,
   input  logic RST,
   input  logic Pin_In,
   output logic H2L_Sig,
   output logic Pin_Sync
);

   logic sync_1;
   logic sync_2;
   logic hist;

   // Preset to the idle-high level so reset release never looks like an edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
         hist   <= 1'b1;
      end else begin
         sync_1 <= Pin_In;
         sync_2 <= sync_1;
         hist   <= sync_2;
      end
   end

   assign Pin_Sync = sync_2;
   assign H2L_Sig  = hist & ~sync_2;

endmodule

// File: rtl/rx_control_module.sv
// UART frame receiver: start/data/stop sequencing driven by an external
// mid-bit strobe, with framing-error detection and break lockout.
module rx_control_module
   import rx_control_module_pkg::*;
#(
   parameter int DATA_BITS = DATA_BITS_DEF
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RX_Pin_In,
   input  logic       RX_En,
   input  logic       BPS_CLK,
   output logic       Count_Sig,
   output logic [7:0] RX_Data,
   output logic       RX_Done_Sig,
   output logic       Frame_Err,
   output logic [2:0] state_dbg
);

   localparam logic [2:0] LAST_IDX = 3'(DATA_BITS - 1);

   // RX_Done_Sig is a valid-only strobe: RX_Data is stable from that cycle
   // until the next strobe and there is no ready/backpressure path.

   rx_state_e              state;
   rx_state_e              state_next;
   logic                   h2l;
   logic                   pin_sync;
   logic [DATA_BITS-1:0]   shift_reg;
   logic [2:0]             bit_idx;
   logic                   shift_en;
   logic                   load_en;
   logic                   err_en;

   rx_h2l_detect u_h2l (
      .CLK      (CLK),
      .RST      (RST),
      .Pin_In   (RX_Pin_In),
      .H2L_Sig  (h2l),
      .Pin_Sync (pin_sync)
   );

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      Count_Sig  = 1'b0;
      shift_en   = 1'b0;
      load_en    = 1'b0;
      err_en     = 1'b0;
      case (state)
         IDLE: begin
            if (RX_En && h2l) state_next = START;
         end
         START: begin
            Count_Sig = 1'b1;
            if (BPS_CLK) state_next = pin_sync ? IDLE : DATA;
         end
         DATA: begin
            Count_Sig = 1'b1;
            if (BPS_CLK) begin
               shift_en = 1'b1;
               if (bit_idx == LAST_IDX) state_next = STOP;
            end
         end
         STOP: begin
            Count_Sig = 1'b1;
            if (BPS_CLK) begin
               if (pin_sync) begin
                  load_en    = 1'b1;
                  state_next = IDLE;
               end else begin
                  err_en     = 1'b1;
                  state_next = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            if (pin_sync) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Pulses are registered so they land in the first cycle of IDLE/WAIT_HIGH,
   // i.e. the same cycle Count_Sig drops.
   always_ff @(posedge CLK) begin
      if (RST) begin
         shift_reg   <= '0;
         bit_idx     <= 3'd0;
         RX_Data     <= 8'd0;
         RX_Done_Sig <= 1'b0;
         Frame_Err   <= 1'b0;
      end else begin
         RX_Done_Sig <= load_en;
         Frame_Err   <= err_en;
         if (shift_en) begin
            shift_reg <= {pin_sync, shift_reg[DATA_BITS-1:1]};
            bit_idx   <= (bit_idx == LAST_IDX) ? 3'd0 : bit_idx + 3'd1;
         end
         if (load_en) RX_Data <= 8'(shift_reg);
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_rx_control_module.sv
// Directed bench for rx_control_module: models the baud counter and drives
// whole serial frames at 5208 clocks per bit.
module tb_rx_control_module;
   import rx_control_module_pkg::*;

   localparam int BIT = BPS_FULL;

   logic       clk;
   logic       rst;
   logic       rx_pin;
   logic       rx_en;
   logic       bps_clk;
   logic       count_sig;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       frame_err;
   logic [2:0] state_dbg;

   int         checks;
   int         errors;
   longint     cyc;
   int         done_cnt;
   int         err_cnt;
   int         excl_viol;
   int         drop_viol;
   int         width_viol;
   logic       prev_count;
   logic       prev_done;
   logic       prev_err;
   logic [7:0] exp_q[$];
   logic [7:0] exp_v;
   longint     done_cyc[$];
   logic [12:0] bps_cnt;

   rx_control_module dut (
      .CLK         (clk),
      .RST         (rst),
      .RX_Pin_In   (rx_pin),
      .RX_En       (rx_en),
      .BPS_CLK     (bps_clk),
      .Count_Sig   (count_sig),
      .RX_Data     (rx_data),
      .RX_Done_Sig (rx_done),
      .Frame_Err   (frame_err),
      .state_dbg   (state_dbg)
   );

   // clock / reset-independent infrastructure
   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // baud counter model: cleared while Count_Sig is low, mid-bit strobe
   always @(posedge clk) begin
      if (!count_sig)                 bps_cnt <= '0;
      else if (bps_cnt == BPS_FULL-1) bps_cnt <= '0;
      else                            bps_cnt <= bps_cnt + 13'd1;
   end
   assign bps_clk = count_sig && (bps_cnt == 13'(BPS_HALF));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
            check("done_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               exp_v = exp_q.pop_front();
               check("rx_data_sb", 32'(rx_data), 32'(exp_v));
            end
         end
         if (frame_err) err_cnt++;
         if (rx_done && frame_err) excl_viol++;
         if ((rx_done || frame_err) && (count_sig || !prev_count)) drop_viol++;
         if ((rx_done && prev_done) || (frame_err && prev_err)) width_viol++;
      end
      prev_count = count_sig;
      prev_done  = rx_done;
      prev_err   = frame_err;
   end

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drives start, 8 data bits LSB first and stop. rst_bit/en_off_bit name a
   // data bit in whose middle RST is pulsed / RX_En is dropped (-1 = none).
   task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                             input int rst_bit, input int en_off_bit);
      for (int s = 0; s < 10; s++) begin
         if (s == 0)      rx_pin = 1'b0;
         else if (s == 9) rx_pin = stop_bit;
         else             rx_pin = data[s-1];
         for (int c = 0; c < BIT; c++) begin
            if (s >= 1 && s <= 8) begin
               if (s - 1 == rst_bit && c == BIT/2)     rst = 1'b1;
               if (s - 1 == rst_bit && c == BIT/2 + 1) rst = 1'b0;
               if (s - 1 == en_off_bit && c == BIT/2)  rx_en = 1'b0;
            end
            @(negedge clk);
         end
      end
   endtask

   int d0, e0;
   longint gap;

   initial begin
      checks = 0; errors = 0; cyc = 0;
      done_cnt = 0; err_cnt = 0;
      excl_viol = 0; drop_viol = 0; width_viol = 0;
      prev_count = 1'b0; prev_done = 1'b0; prev_err = 1'b0;
      rst = 1'b1; rx_pin = 1'b1; rx_en = 1'b1;
      idle_cycles(5);
      rst = 1'b0;
      idle_cycles(2);

      check("rst_count_sig", 32'(count_sig), 32'd0);
      check("rst_rx_data",   32'(rx_data),   32'h00);
      check("rst_done",      32'(rx_done),   32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_state",     32'(state_dbg), 32'(IDLE));

      // Scenario 1: 0xA5 good frame
      d0 = done_cnt; e0 = err_cnt;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, -1, -1);
      idle_cycles(BIT);
      check("s1_done_cnt", 32'(done_cnt - d0), 32'd1);
      check("s1_err_cnt",  32'(err_cnt - e0),  32'd0);
      check("s1_rx_data",  32'(rx_data),       32'hA5);
      check("s1_count_sig", 32'(count_sig),    32'd0);

      // Scenario 2: 1000-cycle low glitch
      d0 = done_cnt; e0 = err_cnt;
      rx_pin = 1'b0;
      idle_cycles(500);
      check("s2_in_start", 32'(state_dbg), 32'(START));
      check("s2_count_hi", 32'(count_sig), 32'd1);
      idle_cycles(500);
      rx_pin = 1'b1;
      idle_cycles(3000);
      check("s2_state",     32'(state_dbg),     32'(IDLE));
      check("s2_count_sig", 32'(count_sig),     32'd0);
      check("s2_done_cnt",  32'(done_cnt - d0), 32'd0);
      check("s2_err_cnt",   32'(err_cnt - e0),  32'd0);
      check("s2_rx_data",   32'(rx_data),       32'hA5);

      // Scenario 3: 0x3C with low stop bit, break held, then 0x55
      d0 = done_cnt; e0 = err_cnt;
      send_frame(8'h3C, 1'b0, -1, -1);
      idle_cycles(10000);
      check("s3_wait_high", 32'(state_dbg),     32'(WAIT_HIGH));
      check("s3_count_lo",  32'(count_sig),     32'd0);
      idle_cycles(10000);
      check("s3_err_cnt",   32'(err_cnt - e0),  32'd1);
      check("s3_done_cnt",  32'(done_cnt - d0), 32'd0);
      check("s3_rx_data",   32'(rx_data),       32'hA5);
      rx_pin = 1'b1;
      idle_cycles(10);
      check("s3_back_idle", 32'(state_dbg),     32'(IDLE));
      idle_cycles(BIT);
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b1, -1, -1);
      idle_cycles(BIT);
      check("s3_rx_data_55", 32'(rx_data),      32'h55);
      check("s3_done_cnt2",  32'(done_cnt - d0), 32'd1);

      // Scenario 4: RST during data bit 4 of 0xFF, then 0x81
      d0 = done_cnt; e0 = err_cnt;
      send_frame(8'hFF, 1'b1, 4, -1);
      idle_cycles(BIT);
      check("s4_rx_data",   32'(rx_data),       32'h00);
      check("s4_count_sig", 32'(count_sig),     32'd0);
      check("s4_state",     32'(state_dbg),     32'(IDLE));
      check("s4_no_done",   32'(done_cnt - d0), 32'd0);
      check("s4_no_err",    32'(err_cnt - e0),  32'd0);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1, -1, -1);
      idle_cycles(BIT);
      check("s4_rx_data_81", 32'(rx_data),      32'h81);

      // Scenario 5: disabled receive, then enable dropped mid-frame
      d0 = done_cnt; e0 = err_cnt;
      rx_en = 1'b0;
      send_frame(8'h12, 1'b1, -1, -1);
      idle_cycles(BIT);
      check("s5_off_done",  32'(done_cnt - d0), 32'd0);
      check("s5_off_data",  32'(rx_data),       32'h81);
      check("s5_off_state", 32'(state_dbg),     32'(IDLE));
      rx_en = 1'b1;
      idle_cycles(100);
      exp_q.push_back(8'h34);
      send_frame(8'h34, 1'b1, -1, 2);
      idle_cycles(BIT);
      check("s5_rx_data_34", 32'(rx_data),      32'h34);
      check("s5_done_cnt",   32'(done_cnt - d0), 32'd1);
      rx_en = 1'b1;
      idle_cycles(100);

      // Scenario 6: back-to-back 0x00 then 0xFF
      d0 = done_cnt; e0 = err_cnt;
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      send_frame(8'h00, 1'b1, -1, -1);
      send_frame(8'hFF, 1'b1, -1, -1);
      idle_cycles(BIT);
      check("s6_done_cnt", 32'(done_cnt - d0), 32'd2);
      check("s6_err_cnt",  32'(err_cnt - e0),  32'd0);
      check("s6_rx_data",  32'(rx_data),       32'hFF);
      if (done_cyc.size() >= 2) begin
         gap = done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2];
         check("s6_gap_in_range", 32'(gap >= 52079 && gap <= 52081), 32'd1);
      end

      // global properties
      check("exp_q_drained",   32'(exp_q.size()), 32'd0);
      check("done_err_excl",   32'(excl_viol),    32'd0);
      check("count_drop_sync", 32'(drop_viol),    32'd0);
      check("pulse_width",     32'(width_viol),   32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
